// File: rtl/dffram_1r1w_clr_if.sv
// Host-side bus for dffram_1r1w_clr: one write port, one read port,
// clear request and busy flag. The master is the bus adapter and the
// slave is the RAM.
interface dffram_1r1w_clr_if #(
  parameter int WSIZE = 4,
  parameter int AW    = 7
) ();
  logic                 CLR;
  logic                 BUSY;
  logic                 EN0;
  logic [WSIZE-1:0]     WE0;
  logic [AW-1:0]        A0;
  logic [8*WSIZE-1:0]   Di0;
  logic                 EN1;
  logic [AW-1:0]        A1;
  logic [8*WSIZE-1:0]   Do1;

  modport master (
    output CLR, EN0, WE0, A0, Di0, EN1, A1,
    input  BUSY, Do1
  );

  modport slave (
    input  CLR, EN0, WE0, A0, Di0, EN1, A1,
    output BUSY, Do1
  );
endinterface

// File: rtl/dffram_1r1w_clr.sv
// Flip-flop RAM, one write port + one registered read port, byte write
// enables, and a clear sequencer that zeroes every word after reset or
// on a CLR request. Host access is locked out while BUSY is high.
//
// Optional feature: define DFFRAM_BYPASS_EN to forward same-address
// write data (byte-merged) to the read port; otherwise a same-edge
// read returns the old stored word.
//
// state | meaning
// CLEAR | sequencer owns the array, zeroing word cnt each cycle
// IDLE  | host reads and writes accepted
module dffram_1r1w_clr #(
  parameter int WSIZE = 4,
  parameter int AW    = 7
) (
  input  logic               CLK,
  input  logic               RESETn,
  dffram_1r1w_clr_if.slave   bus
);

  localparam int DW    = 8 * WSIZE;
  localparam int DEPTH = 2 ** AW;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [AW-1:0]     cnt_q;
  logic [DW-1:0]     mem [DEPTH];
  logic [DW-1:0]     do1_q;
  logic              busy;
  logic [WSIZE-1:0]  wr_be;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [DW-1:0]     rd_word;

  // State register; reset restarts the clear from word 0.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state_q <= CLEAR;
    else         state_q <= state_d;
  end

  // Next state: leave CLEAR after the last word, enter it on CLR.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR: if (cnt_q == AW'(DEPTH - 1)) state_d = IDLE;
      IDLE:  if (bus.CLR)                 state_d = CLEAR;
      default: state_d = CLEAR;
    endcase
  end

  // FSM outputs: BUSY comes straight from the state register.
  always_comb begin
    busy = (state_q == CLEAR);
  end

  // Clear counter; idles at zero so a CLR always starts from word 0.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn)   cnt_q <= '0;
    else if (busy) cnt_q <= cnt_q + 1'b1;
    else           cnt_q <= '0;
  end

  // Write-port mux: the sequencer takes the port while clearing.
  always_comb begin
    wr_be   = '0;
    wr_addr = bus.A0;
    wr_data = bus.Di0;
    if (busy) begin
      wr_be   = '1;
      wr_addr = cnt_q;
      wr_data = '0;
    end else if (bus.EN0) begin
      wr_be   = bus.WE0;
    end
  end

  // Storage array; deliberately not reset, the clear sequencer zeroes it.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < WSIZE; i++) begin
      if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
    end
  end

  // Read word selection, with optional same-address write forwarding.
  always_comb begin
    rd_word = mem[bus.A1];
`ifdef DFFRAM_BYPASS_EN
    if (bus.EN0 && (bus.A0 == bus.A1)) begin
      for (int i = 0; i < WSIZE; i++) begin
        if (bus.WE0[i]) rd_word[8*i +: 8] = bus.Di0[8*i +: 8];
      end
    end
`endif
  end

  // Registered read data; holds while disabled or clearing.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn)                 do1_q <= '0;
    else if (!busy && bus.EN1)   do1_q <= rd_word;
  end

  assign bus.Do1  = do1_q;
  assign bus.BUSY = busy;

endmodule

// File: tb/tb_dffram_1r1w_clr.sv
// Self-checking bench for dffram_1r1w_clr: directed scenarios plus random
// traffic against a word-level reference model.
module tb_dffram_1r1w_clr;

  localparam int WSIZE = 4;
  localparam int AW    = 7;
  localparam int DEPTH = 2 ** AW;

`ifdef DFFRAM_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic CLK;
  logic RESETn;

  dffram_1r1w_clr_if #(.WSIZE(WSIZE), .AW(AW)) bus ();

  dffram_1r1w_clr #(.WSIZE(WSIZE), .AW(AW)) dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .bus    (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] ref_do;
  int          busy_left;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ref_do    = '0;
    busy_left = DEPTH;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  // One clock edge of the abstract model: a clear is a countdown of DEPTH
  // edges that wipes the array; host traffic only counts when not clearing.
  task automatic model_edge();
    logic [31:0] new_w;
    if (busy_left > 0) begin
      busy_left--;
    end else begin
      new_w = ref_mem[bus.A0];
      for (int i = 0; i < WSIZE; i++)
        if (bus.WE0[i]) new_w[8*i +: 8] = bus.Di0[8*i +: 8];
      if (bus.EN1) begin
        if (BYPASS && bus.EN0 && (bus.A0 == bus.A1)) ref_do = new_w;
        else                                         ref_do = ref_mem[bus.A1];
      end
      if (bus.EN0) ref_mem[bus.A0] = new_w;
      if (bus.CLR) begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        busy_left = DEPTH;
      end
    end
  endtask

  task automatic step();
    @(posedge CLK);
    if (RESETn) model_edge();
    #1;
    chk("do1", bus.Do1, ref_do);
    chk("busy", {31'b0, bus.BUSY}, {31'b0, busy_left > 0});
  endtask

  task automatic idle_inputs();
    bus.CLR = 1'b0;
    bus.EN0 = 1'b0;
    bus.WE0 = '0;
    bus.A0  = '0;
    bus.Di0 = '0;
    bus.EN1 = 1'b0;
    bus.A1  = '0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.EN0 = 1'b1; bus.A0 = a; bus.Di0 = d; bus.WE0 = be;
    step();
    idle_inputs();
  endtask

  task automatic rd(input logic [AW-1:0] a);
    bus.EN1 = 1'b1; bus.A1 = a;
    step();
    idle_inputs();
  endtask

  task automatic apply_reset();
    RESETn = 1'b0;
    #1;
    model_reset();
    chk("rst_do1", bus.Do1, 32'h0);
    chk("rst_busy", {31'b0, bus.BUSY}, 32'h1);
    repeat (2) @(posedge CLK);
    #2;
    RESETn = 1'b1;
  endtask

  task automatic run_clear(input string tag);
    int busy_cycles;
    busy_cycles = 0;
    for (int i = 0; i < DEPTH + 4; i++) begin
      if (bus.BUSY) busy_cycles++;
      step();
    end
    chk(tag, busy_cycles, DEPTH);
  endtask

  initial begin
    RESETn = 1'b1;
    idle_inputs();
    #2;

    // Reset and full clear, then every word reads zero.
    apply_reset();
    run_clear("busy_len_reset");
    for (int i = 0; i < DEPTH; i++) begin
      rd(AW'(i));
      chk("clear_word", bus.Do1, 32'h0);
    end

    // Byte-enable merge.
    wr(7'd5, 32'hAABBCCDD, 4'b1111);
    wr(7'd5, 32'h11223344, 4'b0101);
    rd(7'd5);
    chk("byte_merge", bus.Do1, 32'hAA22CC44);
    wr(7'd5, 32'h55667788, 4'b0000);
    rd(7'd5);
    chk("we_zero_noop", bus.Do1, 32'hAA22CC44);

    // Same-address read during write.
    wr(7'd9, 32'h0, 4'b1111);
    bus.EN0 = 1'b1; bus.A0 = 7'd9; bus.Di0 = 32'hDEADBEEF; bus.WE0 = 4'b1111;
    bus.EN1 = 1'b1; bus.A1 = 7'd9;
    step();
    idle_inputs();
    chk("rdw_same", bus.Do1, BYPASS ? 32'hDEADBEEF : 32'h0);
    rd(7'd9);
    chk("rdw_next", bus.Do1, 32'hDEADBEEF);

    // Read and write to different addresses on one edge.
    wr(7'd20, 32'h01020304, 4'b1111);
    bus.EN0 = 1'b1; bus.A0 = 7'd21; bus.Di0 = 32'hCAFEF00D; bus.WE0 = 4'b1111;
    bus.EN1 = 1'b1; bus.A1 = 7'd20;
    step();
    idle_inputs();
    chk("rdw_diff", bus.Do1, 32'h01020304);

    // Address extremes do not alias.
    wr(7'd0,   32'h0000A5A5, 4'b1111);
    wr(7'd127, 32'h5A5A0000, 4'b1111);
    rd(7'd0);
    chk("wrap_lo", bus.Do1, 32'h0000A5A5);
    rd(7'd127);
    chk("wrap_hi", bus.Do1, 32'h5A5A0000);

    // Random traffic, occasional CLR.
    for (int n = 0; n < 600; n++) begin
      bus.EN0 = 1'($urandom);
      bus.WE0 = 4'($urandom);
      bus.A0  = AW'($urandom);
      bus.Di0 = $urandom;
      bus.EN1 = 1'($urandom);
      bus.A1  = ($urandom_range(0, 3) == 0) ? bus.A0 : AW'($urandom);
      bus.CLR = ($urandom_range(0, 99) == 0);
      step();
    end
    idle_inputs();
    repeat (DEPTH + 2) step();

    // CLR from idle with a fully populated array; writes during BUSY dropped.
    for (int i = 0; i < DEPTH; i++) wr(AW'(i), 32'h8000_0000 | 32'(i + 1), 4'b1111);
    bus.CLR = 1'b1;
    step();
    idle_inputs();
    chk("clr_busy_rise", {31'b0, bus.BUSY}, 32'h1);
    begin
      int busy_cycles;
      busy_cycles = 1;
      for (int i = 0; i < DEPTH + 4; i++) begin
        if (bus.BUSY) begin
          bus.EN0 = 1'b1; bus.A0 = 7'd3; bus.Di0 = 32'hBAD0BAD0; bus.WE0 = 4'b1111;
          bus.EN1 = 1'b1; bus.A1 = 7'd3;
          bus.CLR = 1'b0;
          busy_cycles++;
        end else begin
          idle_inputs();
        end
        step();
      end
      idle_inputs();
      chk("busy_len_clr", busy_cycles - 1, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      rd(AW'(i));
      chk("clr_word", bus.Do1, 32'h0);
    end

    // Reset in the middle of a clear restarts it from scratch.
    wr(7'd40, 32'h12345678, 4'b1111);
    rd(7'd40);
    bus.CLR = 1'b1;
    step();
    idle_inputs();
    repeat (59) step();
    apply_reset();
    run_clear("busy_len_midrst");
    rd(7'd40);
    chk("midrst_word", bus.Do1, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
